// File: rtl/output_pipeline.sv
// rtl/output_pipeline.sv - remaps m1 image words through the scratchpad equalization LUT into m4
// Optional build macro: OUTPUT_TAG_CHECK_EN (a lane keeps its source pixel unless the LUT tag is 16'hAAAA)
module output_pipeline #(
  parameter int NUM_WORDS = 4
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] m1ReadVal,
  input  logic [127:0] lutReadVal,
  input  logic         lutBaseOffset,
  output logic [15:0]  m1ReadAddr,
  output logic [15:0]  lutReadAddr,
  output logic [15:0]  m4WriteAddr,
  output logic [127:0] m4WriteVal,
  output logic         m4WE,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_LOOKUP, S_COLLECT, S_WRITE, S_DONE
  } state_t;

  localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);
  localparam logic [15:0] TAG_VALID = 16'hAAAA;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic [15:0]   w_q, w_d;
  logic [3:0]    k_q, k_d;
  logic [127:0]  word_q, word_d;
  logic [127:0]  result_q, result_d;
  logic [15:0]   m1_addr_q, m1_addr_d;
  logic [15:0]   lut_addr_q, lut_addr_d;
  logic [15:0]   wr_addr_q, wr_addr_d;
  logic [127:0]  wr_val_q, wr_val_d;
  logic          we_q, we_d;
  logic          done_q, done_d;

  logic          lane_capture;
  logic [3:0]    lane;
  logic [7:0]    lane_pixel;
  logic [7:0]    lane_val;
  logic          unused_bits;

  // start is registered so the FSM leaves IDLE one edge after it is sampled
  assign start_d = (state_q == S_IDLE) && start;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_q) state_d = S_FETCH;
      S_FETCH:   state_d = S_LATCH;
      S_LATCH:   state_d = S_LOOKUP;
      S_LOOKUP:  if (k_q == 4'd15) state_d = S_COLLECT;
      S_COLLECT: state_d = S_WRITE;
      S_WRITE:   state_d = (w_q == LAST_WORD) ? S_DONE : S_FETCH;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // LUT data trails its address by one cycle; k has already advanced (and wrapped to 0 in COLLECT)
  assign lane_capture = ((state_q == S_LOOKUP) && (k_q != 4'd0)) || (state_q == S_COLLECT);
  assign lane         = k_q - 4'd1;
  assign lane_pixel   = word_q[{lane, 3'b000} +: 8];

`ifdef OUTPUT_TAG_CHECK_EN
  assign lane_val    = (lutReadVal[31:16] == TAG_VALID) ? lutReadVal[7:0] : lane_pixel;
  assign unused_bits = ^{lutReadVal[127:32], lutReadVal[15:8]};
`else
  assign lane_val    = lutReadVal[7:0];
  assign unused_bits = ^{lutReadVal[127:8], lane_pixel, TAG_VALID};
`endif

  always_comb begin
    w_d        = w_q;
    k_d        = k_q;
    word_d     = word_q;
    result_d   = result_q;
    m1_addr_d  = m1_addr_q;
    lut_addr_d = lut_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_val_d   = wr_val_q;
    we_d       = 1'b0;
    done_d     = (state_d == S_DONE);

    if (state_q == S_LATCH) word_d = m1ReadVal;
    if (state_q == S_LOOKUP) k_d = k_q + 4'd1;
    if ((state_q == S_WRITE) && (state_d == S_FETCH)) w_d = w_q + 16'd1;
    if (lane_capture) result_d[{lane, 3'b000} +: 8] = lane_val;

    // registered outputs are loaded from next-state values so they line up with state_q
    if (state_d == S_FETCH) m1_addr_d = w_d;
    if (state_d == S_LOOKUP) lut_addr_d = {7'b0, lutBaseOffset, word_d[{k_d, 3'b000} +: 8]};
    if (state_d == S_WRITE) begin
      we_d      = 1'b1;
      wr_addr_d = w_q;
      wr_val_d  = result_d;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      w_q        <= '0;
      k_q        <= '0;
      word_q     <= '0;
      result_q   <= '0;
      m1_addr_q  <= '0;
      lut_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_val_q   <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      w_q        <= w_d;
      k_q        <= k_d;
      word_q     <= word_d;
      result_q   <= result_d;
      m1_addr_q  <= m1_addr_d;
      lut_addr_q <= lut_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_val_q   <= wr_val_d;
      we_q       <= we_d;
      done_q     <= done_d;
    end
  end

  assign m1ReadAddr  = m1_addr_q;
  assign lutReadAddr = lut_addr_q;
  assign m4WriteAddr = wr_addr_q;
  assign m4WriteVal  = wr_val_q;
  assign m4WE        = we_q;
  assign done        = done_q;

endmodule

// File: tb/tb_output_pipeline.sv
// tb/tb_output_pipeline.sv - table-driven and randomized checks of output_pipeline against a LUT model
module tb_output_pipeline;

  logic         clock;
  logic         rst_n;
  logic         start, start1;
  logic         lutBaseOffset;
  logic [127:0] m1ReadVal, lutReadVal, m1ReadVal1, lutReadVal1;
  logic [15:0]  m1ReadAddr, lutReadAddr, m4WriteAddr;
  logic [15:0]  m1ReadAddr1, lutReadAddr1, m4WriteAddr1;
  logic [127:0] m4WriteVal, m4WriteVal1;
  logic         m4WE, done, m4WE1, done1;

  logic [127:0] m1_mem  [16];
  logic [127:0] lut_mem [512];

  int vectors = 0;
  int miscompares = 0;

  output_pipeline #(.NUM_WORDS(4)) dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .m1ReadVal(m1ReadVal), .lutReadVal(lutReadVal), .lutBaseOffset(lutBaseOffset),
    .m1ReadAddr(m1ReadAddr), .lutReadAddr(lutReadAddr), .m4WriteAddr(m4WriteAddr),
    .m4WriteVal(m4WriteVal), .m4WE(m4WE), .done(done)
  );

  output_pipeline #(.NUM_WORDS(1)) dut1 (
    .clock(clock), .rst_n(rst_n), .start(start1),
    .m1ReadVal(m1ReadVal1), .lutReadVal(lutReadVal1), .lutBaseOffset(lutBaseOffset),
    .m1ReadAddr(m1ReadAddr1), .lutReadAddr(lutReadAddr1), .m4WriteAddr(m4WriteAddr1),
    .m4WriteVal(m4WriteVal1), .m4WE(m4WE1), .done(done1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    m1ReadVal   <= m1_mem[m1ReadAddr[3:0]];
    lutReadVal  <= lut_mem[lutReadAddr[8:0]];
    m1ReadVal1  <= m1_mem[m1ReadAddr1[3:0]];
    lutReadVal1 <= lut_mem[lutReadAddr1[8:0]];
  end

  typedef struct {
    int           lut_mode;
    bit           bank;
    int           m1_mode;
    bit           has_exp;
    logic [127:0] exp0;
  } vec_t;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every byte is looked up independently in the selected bank; tag gating only in the checked build
  function automatic logic [127:0] model_word(input logic [127:0] src, input bit bank);
    logic [127:0] r;
    logic [127:0] e;
    logic [7:0]   p;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      p = src[8*b +: 8];
      e = lut_mem[{bank, p}];
`ifdef OUTPUT_TAG_CHECK_EN
      r[8*b +: 8] = (e[31:16] == 16'hAAAA) ? e[7:0] : p;
`else
      r[8*b +: 8] = e[7:0];
`endif
    end
    return r;
  endfunction

  task automatic fill_lut(input int mode);
    logic [7:0]  p;
    logic [15:0] tag;
    for (int i = 0; i < 512; i++) begin
      p = 8'(i);
      tag = ($urandom_range(0, 1) == 1) ? 16'hAAAA : 16'($urandom);
      case (mode)
        0: lut_mem[i] = {32'($urandom), 32'($urandom), 32'($urandom), 16'hAAAA, 8'h00, p};
        1: lut_mem[i] = {32'($urandom), 32'($urandom), 32'($urandom), 16'hAAAA, 8'h00, ~p};
        2: lut_mem[i] = (p == 8'h10) ? {96'd0, 32'h0000_0055}
                                     : {32'($urandom), 32'($urandom), 32'($urandom), 16'hAAAA, 8'h00, p};
        default: lut_mem[i] = {32'($urandom), 32'($urandom), 32'($urandom), tag, 16'($urandom)};
      endcase
    end
  endtask

  task automatic fill_m1(input int mode);
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 16; b++)
        case (mode)
          0: m1_mem[w][8*b +: 8] = 8'(16*w + b);
          1: m1_mem[w][8*b +: 8] = 8'($urandom);
          default: m1_mem[w][8*b +: 8] = ($urandom_range(0, 2) == 0) ? 8'h10 : 8'($urandom);
        endcase
    if (mode == 2) m1_mem[0] = {8{16'h1011}};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  // Cycle c is sampled 1 time unit after the c-th rising edge following the start edge
  task automatic run_and_check(input int id, input bit has_exp, input logic [127:0] exp0, input bit bank);
    int bad_we, bad_done, bad_addr, wi, off, k;
    logic [15:0] ea;
    bad_we = 0; bad_done = 0; bad_addr = 0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= 95; c++) begin
      @(posedge clock);
      #1;
      if ((c % 20 == 0) && (c / 20 >= 1) && (c / 20 <= 4)) begin
        wi = c / 20 - 1;
        check($sformatf("r%0d_we_w%0d", id, wi), 128'(m4WE), 128'd1);
        check($sformatf("r%0d_addr_w%0d", id, wi), 128'(m4WriteAddr), 128'(wi));
        check($sformatf("r%0d_val_w%0d", id, wi), m4WriteVal, model_word(m1_mem[wi], bank));
        if (wi == 0 && has_exp) check($sformatf("r%0d_table_w0", id), m4WriteVal, exp0);
      end else if (m4WE !== 1'b0) begin
        bad_we++;
      end
      if (done !== (c >= 81)) bad_done++;
      wi = (c - 1) / 20;
      off = c - 20 * wi;
      if (wi < 4) begin
        if (off == 1 && m1ReadAddr !== 16'(wi)) bad_addr++;
        if (off >= 3 && off <= 18) begin
          k = off - 3;
          ea = {7'b0, bank, m1_mem[wi][8*k +: 8]};
          if (lutReadAddr !== ea) bad_addr++;
        end
      end
    end
    check($sformatf("r%0d_we_timing_bad", id), 128'(bad_we), 128'd0);
    check($sformatf("r%0d_done_timing_bad", id), 128'(bad_done), 128'd0);
    check($sformatf("r%0d_read_addr_bad", id), 128'(bad_addr), 128'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int bad;
    clock = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    lutBaseOffset = 1'b0;

    vecs[0] = '{lut_mode: 0, bank: 0, m1_mode: 0, has_exp: 1, exp0: 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[1] = '{lut_mode: 1, bank: 1, m1_mode: 0, has_exp: 1, exp0: 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF};
`ifdef OUTPUT_TAG_CHECK_EN
    vecs[2] = '{lut_mode: 2, bank: 0, m1_mode: 2, has_exp: 1, exp0: {8{16'h1011}}};
`else
    vecs[2] = '{lut_mode: 2, bank: 0, m1_mode: 2, has_exp: 1, exp0: {8{16'h5511}}};
`endif
    vecs[3] = '{lut_mode: 0, bank: 1, m1_mode: 1, has_exp: 0, exp0: '0};
    vecs[4] = '{lut_mode: 3, bank: 0, m1_mode: 1, has_exp: 0, exp0: '0};
    vecs[5] = '{lut_mode: 3, bank: 1, m1_mode: 2, has_exp: 0, exp0: '0};

    fill_lut(0);
    fill_m1(0);
    do_reset();
    check("reset_outputs", {m1ReadAddr, lutReadAddr, m4WriteAddr, m4WriteVal, m4WE, done}, '0);

    for (int i = 0; i < 6; i++) begin
      fill_lut(vecs[i].lut_mode);
      fill_m1(vecs[i].m1_mode);
      lutBaseOffset = vecs[i].bank;
      do_reset();
      run_and_check(i, vecs[i].has_exp, vecs[i].exp0, vecs[i].bank);
    end

    // reset while word 2 is at lookup k=5 (cycle 48)
    fill_lut(0);
    fill_m1(0);
    lutBaseOffset = 1'b0;
    do_reset();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (48) @(posedge clock);
    #1;
    check("midrun_position", 128'(lutReadAddr), 128'h25);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {m1ReadAddr, lutReadAddr, m4WriteAddr, m4WriteVal, m4WE, done}, '0);
    bad = 0;
    repeat (3) begin
      @(posedge clock);
      #1 if (m4WE !== 1'b0) bad++;
    end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clock);
      #1 if (m4WE !== 1'b0 || done !== 1'b0) bad++;
    end
    check("midrun_no_write_bad", 128'(bad), 128'd0);
    run_and_check(10, 1'b1, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0);

    // start low for 50 cycles, then a pulse, then a pulse while done
    do_reset();
    bad = 0;
    repeat (50) begin
      @(posedge clock);
      #1 if (m1ReadAddr !== 16'd0 || lutReadAddr !== 16'd0 || m4WE !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_no_activity_bad", 128'(bad), 128'd0);
    run_and_check(11, 1'b0, '0, 1'b0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bad = 0;
    repeat (60) begin
      @(posedge clock);
      #1 if (m4WE !== 1'b0 || done !== 1'b1) bad++;
    end
    check("done_start_ignored_bad", 128'(bad), 128'd0);

    // single-word instance
    fill_lut(3);
    fill_m1(1);
    lutBaseOffset = 1'b1;
    do_reset();
    bad = 0;
    @(negedge clock);
    start1 = 1'b1;
    @(posedge clock);
    #1 start1 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock);
      #1;
      if (c == 20) begin
        check("nw1_we", 128'(m4WE1), 128'd1);
        check("nw1_addr", 128'(m4WriteAddr1), 128'd0);
        check("nw1_val", m4WriteVal1, model_word(m1_mem[0], 1'b1));
      end else if (m4WE1 !== 1'b0) begin
        bad++;
      end
      if (done1 !== (c >= 21)) bad++;
    end
    check("nw1_timing_bad", 128'(bad), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_pipeline.md
# output_pipeline

Final stage of the histogram equalizer. Re-reads the original image from m1 (16 pixels per 128-bit word, byte 0 = bits [7:0]). Maps every pixel through the equalization lookup table held in scratchpad memory (m2 or m3, selected by the base offset), packs the 16 mapped bytes back into a 128-bit word and writes it to output memory m4. It is the reader-side counterpart of the histogram accumulation stage: it consumes the same tagged scratchpad entry format at the same `{offset, pixel}` addressing.

## Interface
Parameters:
- `NUM_WORDS`, 4, number of 128-bit image words processed, addresses 0..NUM_WORDS-1; must be ≥1.

Ports:
- `clock` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: level; sampled only in IDLE.
- `m1ReadVal` input 128: image word read data.
- `lutReadVal` input 128: scratchpad read data. Bits [31:16] are the tag, bits [7:0] are the mapped pixel; bits [127:32] are ignored.
- `lutBaseOffset` input 1: scratchpad bank select; held stable for a whole run.
- `m1ReadAddr` output 16: image word address.
- `lutReadAddr` output 16: `{7'b0, lutBaseOffset, pixel[7:0]}`.
- `m4WriteAddr` output 16: output word address.
- `m4WriteVal` output 128: packed mapped pixels.
- `m4WE` output 1: write strobe, one cycle per word.
- `done` output 1: run complete; sticky.

## Operation
- Memory model: all memories are synchronous. ReadVal in cycle t+1 corresponds to the ReadAddr driven in cycle t. All outputs are registered.
- States and transitions:
  - IDLE → FETCH when `start`=1.
  - FETCH → LATCH. In FETCH, `m1ReadAddr` = word counter `w`.
  - LATCH → LOOKUP. In LATCH, the word register captures `m1ReadVal`.
  - LOOKUP: 16 cycles, byte index k=0..15. `lutReadAddr` presents byte k of the word register. After k=15 → COLLECT.
  - Lane capture: the result for byte k is captured one cycle after its LOOKUP cycle, into result lane bits [8k+7:8k]. Lane 15 is captured in COLLECT.
  - COLLECT → WRITE.
  - WRITE: `m4WE`=1, `m4WriteAddr`=w, `m4WriteVal`=result. Then, if w = NUM_WORDS-1 → DONE; otherwise w increments → FETCH.
  - DONE: `done`=1 and held; `start` is ignored; exit only via reset.
- Width rules:
  - w is a 16-bit counter and never wraps for legal NUM_WORDS.
  - k is a 4-bit counter.
  - The mapped value is exactly 8 bits; no arithmetic is performed on it.
- `m4WriteAddr` and `m4WriteVal` hold their last values while `m4WE`=0.
- Reset values: all outputs 0. The state register is asynchronously forced to IDLE; w, k, the word register and the result register go to 0.
- Reset mid-run: the in-progress word is discarded and no partial `m4WE` is issued. After release, a new `start` restarts from word 0.
- `start` deasserting mid-run has no effect.

## Timing
- Cycle 0 is the rising edge at which `start`=1 is sampled in IDLE.
- Word w schedule:
  - FETCH: cycle 20w+1.
  - LATCH: cycle 20w+2.
  - LOOKUP: cycles 20w+3 to 20w+18.
  - COLLECT: cycle 20w+19.
  - WRITE (`m4WE`=1): cycle 20w+20.
- `done` rises at cycle 20·NUM_WORDS+1. For the default NUM_WORDS=4, writes occur at cycles 20/40/60/80 and `done` rises at cycle 81.
- Throughput: 20 cycles per word, no overlap between words.
- `m4WE` is never high for two consecutive cycles.

## Configuration
- Macro: `OUTPUT_TAG_CHECK_EN`.
  - Defined: a lane takes `lutReadVal[7:0]` only when `lutReadVal[31:16]` = 16'hAAAA. Otherwise the lane takes the original pixel byte (identity map for bins never written).
  - Undefined: a lane always takes `lutReadVal[7:0]` and the tag is ignored.
- The cycle timing is identical in both builds.

## Test plan
- Identity LUT, bank 0 (entry p = 32'hAAAA00pp), m1 words = distinct byte ramps:
  - m4 words 0..3 equal the m1 words.
  - `m4WE` is high at cycles 20/40/60/80 only.
  - `done`=1 at cycle 81 and stays high.
- Inverting LUT in bank 1 (entry = 32'hAAAA0000 | (255-p)), `lutBaseOffset`=1:
  - All `lutReadAddr` values fall in 0x100-0x1FF.
  - Word 0x0F..00 is written as 0xF0..FF.
- Entry for pixel 0x10 = 32'h00000055, all others identity:
  - With `OUTPUT_TAG_CHECK_EN`, lanes holding 0x10 output 0x10.
  - Without the macro, those lanes output 0x55.
- Assert `rst_n`=0 during word 2 at LOOKUP k=5:
  - All outputs read 0 in the same cycle and no `m4WE` is issued for word 2.
  - Re-start: the run repeats from word 0 with the Timing-section schedule.
- Start handling:
  - `start` held 0 for 50 cycles: no address activity.
  - 1-cycle `start` pulse: a full run.
  - `start` pulsed while in DONE: no new writes.
- NUM_WORDS=1: a single write to address 0 at cycle 20; `done` at cycle 21.
